memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Consumes the request unit's iREN/dREN/dWEN and arbitrates instruction-fetch
//  and data accesses onto the single-ported RAM. Returns ihit/dhit back to the
//  request unit and datapath. Sits between the request unit and the RAM model.
//  Data wins over fetch: a MEM-stage access must retire before the pipeline advances.
// PARAMETERS
//  WDOG_CYCLES  64  Cycles in an access state without ACCESS before err sets; 0 disables the watchdog.
//  WDOG_W       7   Watchdog counter width; must satisfy 2**WDOG_W > WDOG_CYCLES.
// PORTS
//  CLK       in   1   system clock, rising edge
//  nRST      in   1   asynchronous, active-low reset
//  iREN      in   1   instruction read request (from request unit)
//  dREN      in   1   data read request
//  dWEN      in   1   data write request
//  iaddr     in   32  fetch address (word)
//  daddr     in   32  data address (word)
//  dstore    in   32  data write value
//  ramstate  in   2   ramstate_t from cpu_types_pkg: FREE=0 BUSY=1 ACCESS=2 ERROR=3
//  ramload   in   32  RAM read data
//  ihit      out  1   fetch complete this cycle; iload valid
//  dhit      out  1   data access complete this cycle; dload valid on reads
//  iload     out  32  instruction word
//  dload     out  32  data read word
//  ramREN    out  1   RAM read enable
//  ramWEN    out  1   RAM write enable
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  err       out  1   sticky: watchdog expiry, RAM ERROR, or dREN&dWEN together
// BEHAVIOUR
//  - Async reset: state=IDLE, wdog=0, err=0. Outputs: ihit=dhit=0, ramREN=ramWEN=0,
//    ramaddr=ramstore=0, iload=dload=0.
//  - FSM states: IDLE, IACC, DACC. Registered state; all outputs decoded
//    combinationally from state and inputs.
//  - IDLE: drives no RAM enables. Next: DACC if dREN|dWEN, else IACC if iREN, else IDLE.
//  - IACC: ramREN=1, ramaddr=iaddr. When ramstate==ACCESS: ihit=1, iload=ramload,
//    next=IDLE. If iREN drops before ACCESS: next=IDLE, no hit (abort).
//  - DACC: ramaddr=daddr, ramstore=dstore. dWEN -> ramWEN=1, ramREN=0; else ramREN=dREN.
//    When ramstate==ACCESS: dhit=1, dload=ramload (reads only, else 0), next=IDLE.
//    If dREN and dWEN both drop before ACCESS: next=IDLE, no hit.
//  - dREN&dWEN together: write wins; err sets on that edge.
//  - Latency: request sampled in IDLE -> access state next cycle -> hit in the first
//    cycle ramstate==ACCESS. Zero-wait RAM gives hit 1 cycle after the request.
//    One IDLE cycle always separates back-to-back accesses.
//  - No preemption: an IACC in progress completes even if dREN/dWEN rises;
//    the data request wins the next IDLE.
//  - ramstate FREE/BUSY/ERROR in an access state: hold enables, no hit.
//    ERROR additionally sets err.
//  - Watchdog (WDOG_CYCLES>0):
//    - Clears on entering IACC/DACC; increments each cycle there without ACCESS;
//      saturates at WDOG_CYCLES.
//    - Reaching WDOG_CYCLES sets err. The FSM keeps waiting; no forced exit.
//  - err clears only on reset.
//  - nRST asserted mid-access: immediate return to IDLE; enables drop asynchronously.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    - Adds outputs istall_cnt[31:0] and dstall_cnt[31:0], reset 0.
//    - Each increments every cycle iREN (resp. dREN|dWEN) is high without ihit (resp. dhit).
//    - Both wrap at 2**32.
//  ARB_STATS_EN undefined: ports and counters absent. Functional behaviour identical.
// TESTING
//  1 Reset: nRST=0 mid-DACC with ramWEN=1 -> ramWEN=0 same cycle; state IDLE; err=0.
//  2 Fetch, zero-wait RAM: iREN=1, iaddr=0x40, ramstate=ACCESS, ramload=0x8C220004
//    -> ihit=1 on cycle 1 with iload=0x8C220004, ramaddr=0x40.
//  3 Contention: iREN=dREN=1 in IDLE, daddr=0x100
//    -> DACC first, dhit, then IDLE, then IACC, ihit. No simultaneous hits.
//  4 Write with 3 BUSY cycles: dWEN=1, daddr=0x200, dstore=0xDEADBEEF
//    -> ramWEN held 3 cycles, dhit on cycle 4, dload=0.
//  5 Watchdog: WDOG_CYCLES=4, ramstate stuck BUSY in IACC
//    -> err=1 after 4 cycles and stays 1 until reset.
//  6 Abort/illegal:
//    - iREN dropped during BUSY -> IDLE, no ihit.
//    - dREN=dWEN=1 -> ramWEN=1, ramREN=0, err=1.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Arbitrates instruction fetches and data accesses onto a single-ported RAM.
//   Data requests beat fetch requests in IDLE; an access in progress is never
//   preempted. One IDLE cycle always separates consecutive accesses.
//
// Parameters
//   WDOG_CYCLES  cycles in an access state without ACCESS before err sets (0 = off)
//   WDOG_W       watchdog counter width, 2**WDOG_W > WDOG_CYCLES
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   iREN, iaddr          fetch request / word address
//   dREN, dWEN           data read / write request (write wins if both)
//   daddr, dstore        data address / write value
//   ramstate, ramload    RAM status (FREE=0 BUSY=1 ACCESS=2 ERROR=3) / read data
//   ihit, iload          fetch complete / instruction word
//   dhit, dload          data access complete / read word (0 on writes)
//   ramREN, ramWEN       RAM enables
//   ramaddr, ramstore    RAM address / write data
//   err                  sticky: watchdog expiry, RAM ERROR, or dREN&dWEN
//   istall_cnt,
//   dstall_cnt           stall counters, present only with ARB_STATS_EN defined
//
// Optional feature macro: ARB_STATS_EN
module memory_arbiter #(
  parameter int WDOG_CYCLES = 64,
  parameter int WDOG_W      = 7
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        err
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] istall_cnt,
  output logic [31:0] dstall_cnt
`endif
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t state, state_nxt;
  logic   in_acc;
  logic   wdog_trip;

  assign in_acc = (state != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    unique case (state)
      IDLE: begin
        if (dREN || dWEN) state_nxt = DACC;
        else if (iREN)    state_nxt = IACC;
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ramstate == RAM_ACCESS) begin
          ihit      = 1'b1;
          iload     = ramload;
          state_nxt = IDLE;
        end else if (!iREN) begin
          state_nxt = IDLE;  // fetch abandoned by the request unit
        end
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        if (ramstate == RAM_ACCESS) begin
          dhit      = 1'b1;
          dload     = (dREN && !dWEN) ? ramload : '0;
          state_nxt = IDLE;
        end else if (!dREN && !dWEN) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog counts non-ACCESS cycles spent in an access state; it is held at
  // zero in IDLE so every new access starts from a clean count.
  generate
    if (WDOG_CYCLES > 0) begin : g_wdog
      localparam logic [WDOG_W-1:0] WMAX = WDOG_W'(WDOG_CYCLES);
      logic [WDOG_W-1:0] wdog;
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                                  wdog <= '0;
        else if (!in_acc)                           wdog <= '0;
        else if (ramstate != RAM_ACCESS && wdog != WMAX) wdog <= wdog + 1'b1;
      end
      // fires on the edge where the count reaches WMAX
      assign wdog_trip = in_acc && (ramstate != RAM_ACCESS) && (wdog == WMAX - 1'b1);
    end else begin : g_nowdog
      assign wdog_trip = 1'b0;
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) err <= 1'b0;
    else if (wdog_trip || (in_acc && ramstate == RAM_ERROR) || (dREN && dWEN))
      err <= 1'b1;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      istall_cnt <= '0;
      dstall_cnt <= '0;
    end else begin
      if (iREN && !ihit)           istall_cnt <= istall_cnt + 32'd1;
      if ((dREN || dWEN) && !dhit) dstall_cnt <= dstall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef ARB_STATS_EN
  logic [31:0] istall_cnt, dstall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

  memory_arbiter #(.WDOG_CYCLES(4), .WDOG_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ramstate(ramstate),
    .ramload(ramload), .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .err(err)
`ifdef ARB_STATS_EN
    , .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #12;
    // reset state
    chk("rst_ihit", {31'd0, ihit}, 0);
    chk("rst_dhit", {31'd0, dhit}, 0);
    chk("rst_ramREN", {31'd0, ramREN}, 0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_err", {31'd0, err}, 0);
    tick(); nRST = 1'b1;

    // zero-wait fetch: hit one cycle after the request
    tick();
    iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h8C220004;
    #2 chk("f_idle_ramREN", {31'd0, ramREN}, 0);
    tick();
    #2;
    chk("f_ihit", {31'd0, ihit}, 1);
    chk("f_iload", iload, 32'h8C220004);
    chk("f_ramaddr", ramaddr, 32'h40);
    chk("f_ramREN", {31'd0, ramREN}, 1);
    iREN = 0;
    tick();
    #2 chk("f_back_idle", {31'd0, ihit}, 0);

    // contention: data first, one IDLE gap, then fetch
    iREN = 1; dREN = 1; daddr = 32'h100; ramload = 32'h11112222;
    tick();
    #2;
    chk("c_dhit", {31'd0, dhit}, 1);
    chk("c_ihit_lo", {31'd0, ihit}, 0);
    chk("c_dload", dload, 32'h11112222);
    chk("c_ramaddr", ramaddr, 32'h100);
    dREN = 0;
    tick();
    #2;
    chk("c_gap_ihit", {31'd0, ihit}, 0);
    chk("c_gap_dhit", {31'd0, dhit}, 0);
    chk("c_gap_ramREN", {31'd0, ramREN}, 0);
    tick();
    #2;
    chk("c_ihit", {31'd0, ihit}, 1);
    chk("c_dhit_lo", {31'd0, dhit}, 0);
    chk("c_iaddr", ramaddr, 32'h40);
    iREN = 0;
    tick();

    // write with three BUSY cycles
    ramstate = BUSY; dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    tick();
    for (int c = 1; c <= 3; c++) begin
      #2;
      chk("w_ramWEN", {31'd0, ramWEN}, 1);
      chk("w_ramREN", {31'd0, ramREN}, 0);
      chk("w_dhit_lo", {31'd0, dhit}, 0);
      chk("w_ramstore", ramstore, 32'hDEADBEEF);
      tick();
    end
    ramstate = ACCESS;
    #2;
    chk("w_dhit", {31'd0, dhit}, 1);
    chk("w_dload", dload, 0);
    chk("w_ramaddr", ramaddr, 32'h200);
    chk("w_err_lo", {31'd0, err}, 0);
    dWEN = 0;
    tick();

    // watchdog: stuck BUSY in IACC, expires after 4 cycles
    ramstate = BUSY; iREN = 1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      #2 chk("wd_err_lo", {31'd0, err}, 0);
      tick();
    end
    #2;
    chk("wd_err_set", {31'd0, err}, 1);
    chk("wd_ihit_lo", {31'd0, ihit}, 0);
    chk("wd_still_iacc", {31'd0, ramREN}, 1);
    iREN = 0;
    tick();
    tick();
    #2 chk("wd_err_sticky", {31'd0, err}, 1);
    nRST = 0;
    #1 chk("wd_err_rst", {31'd0, err}, 0);
    tick(); nRST = 1;

    // abort: fetch dropped during BUSY
    iREN = 1; ramstate = BUSY;
    tick();
    #2 chk("a_ramREN", {31'd0, ramREN}, 1);
    tick();
    iREN = 0;
    #2 chk("a_ihit_lo", {31'd0, ihit}, 0);
    tick();
    #2;
    chk("a_idle_ramREN", {31'd0, ramREN}, 0);
    chk("a_ihit_idle", {31'd0, ihit}, 0);
    chk("a_err_lo", {31'd0, err}, 0);

    // illegal dREN&dWEN: write wins, err sets
    dREN = 1; dWEN = 1; daddr = 32'h300;
    #1 chk("il_err_pre", {31'd0, err}, 0);
    tick();
    #2;
    chk("il_ramWEN", {31'd0, ramWEN}, 1);
    chk("il_ramREN", {31'd0, ramREN}, 0);
    chk("il_err", {31'd0, err}, 1);

    // reset mid-DACC with ramWEN=1: enables drop immediately
    nRST = 0;
    #1;
    chk("r_ramWEN", {31'd0, ramWEN}, 0);
    chk("r_ramaddr", ramaddr, 0);
    chk("r_err", {31'd0, err}, 0);
    dREN = 0; dWEN = 0;
    tick(); nRST = 1;
    tick();
    #2;
    chk("r_idle_ramREN", {31'd0, ramREN}, 0);
    chk("r_idle_ramWEN", {31'd0, ramWEN}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
